point_on_curve_check: RTL and testbench
=======================================

POINT_ON_CURVE_CHECK -- requirements
Module: point_on_curve_check

Interface
REQ-001 Parameter P_MOD, default 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F, secp256k1 field prime p.
REQ-002 Parameter B_COEF, default 256'd7, curve constant b in y^2 = x^3 + b.
REQ-003 clk  input  1  sole clock; all logic on the rising edge.
REQ-004 reset  input  1  reset is synchronous and active-low.
REQ-005 start  input  1  request a check; sampled only in IDLE.
REQ-006 x  input  256  affine x-coordinate under test, for example a point_double x3 result.
REQ-007 y  input  256  affine y-coordinate under test, for example a point_double y3 result.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle pulse; result outputs are valid in that cycle.
REQ-010 on_curve  output  1  1 when y^2 mod p == (x^3 + b) mod p.
REQ-011 range_err  output  1  1 when x >= p or y >= p.

Function
REQ-012 States SHALL be IDLE, CHK, MUL_XX, MUL_XXX, MUL_YY, CMP and DONE.
REQ-013 IDLE SHALL move to CHK when start=1 and SHALL latch x and y into internal registers in that cycle; later input changes SHALL be ignored.
REQ-014 CHK (1 cycle) SHALL go to DONE with range_err=1 and on_curve=0 if either latched operand >= p; otherwise it SHALL go to MUL_XX.
REQ-015 Each MUL_* state SHALL last exactly 256 cycles and perform one bit-serial interleaved modular multiply, scanning the multiplier MSB first: acc <- (2*acc + bit*a) mod p, with at most two conditional subtractions of p per step.
REQ-016 The multiplies SHALL be: MUL_XX t1 = x*x; MUL_XXX t2 = t1*x; MUL_YY t3 = y*y. All results SHALL be mod p and lie in [0, p-1].
REQ-017 CMP (1 cycle) SHALL compute rhs = (t2 + b) mod p with a 257-bit add and one conditional subtract, then register on_curve = (t3 == rhs) and range_err = 0.
REQ-018 DONE (1 cycle) SHALL assert done and return to IDLE.
REQ-019 Latency, with the start-sample edge as cycle 0: done SHALL be high in cycle 771 for a normal check and in cycle 2 for a range error.
REQ-020 on_curve and range_err SHALL hold their values from one DONE until the next check's CHK or CMP update, or until reset.
REQ-021 start SHALL be ignored while busy=1; no request is queued.
REQ-022 If start=1 in the same cycle as DONE, it SHALL be ignored. If start=1 in the following IDLE cycle, it SHALL be accepted.
REQ-023 The point at infinity has no encoding here. The input (0,0) SHALL be treated as an ordinary point, giving on_curve=0.

Reset
REQ-024 While reset=0 at a clock edge, the state SHALL become IDLE and busy, done, on_curve and range_err SHALL be 0. Internal accumulators and latched operands SHALL be cleared.
REQ-025 Reset asserted mid-operation SHALL abort the check with no done pulse. The first start after reset is released SHALL behave as after power-up.

Structure
REQ-026 A shared package SHALL hold the secp256k1 constants (p, b, Gx, Gy) and the state encoding. point_double and its benches SHALL use the same package.
REQ-027 The single sub-module SHALL be mod_mul_serial (ports: clk, reset, start, a, b, busy, done, r) with a fixed 256-cycle latency. It SHALL be instantiated once and reused for all three multiplies.

Verification
REQ-028 Generator G: x=79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798, y=483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8, start pulse -> done in cycle 771, on_curve=1, range_err=0.
REQ-029 x=Gx, y=Gy+1 -> done in cycle 771, on_curve=0, range_err=0.
REQ-030 x=P_MOD, y=0 -> done in cycle 2, range_err=1, on_curve=0. Also x=0, y=0 -> done in cycle 771, on_curve=0.
REQ-031 G started, then start re-pulsed at cycle 100 with x=0 -> exactly one done pulse, in cycle 771, with on_curve=1.
REQ-032 G started, reset=0 at cycle 300 for 2 cycles -> busy=0, no done pulse. Then a G restart -> on_curve=1 in cycle 771 after the new start.
REQ-033 Chain the point_double output for G into this block -> on_curve=1. Back-to-back checks SHALL complete with one idle cycle between done and the next start.

Source files
------------

// File: rtl/point_on_curve_check_pkg.sv
// Shared secp256k1 constants, FSM encoding and the interleaved modular-multiply step.
// Also imported by point_double and its benches.
package point_on_curve_check_pkg;

    localparam int unsigned W     = 256;
    localparam int unsigned CNT_W = 8;

    localparam logic [W-1:0] SECP_P  = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
    localparam logic [W-1:0] SECP_B  = 256'd7;
    localparam logic [W-1:0] SECP_GX = 256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
    localparam logic [W-1:0] SECP_GY = 256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHK,
        ST_MUL_XX,
        ST_MUL_XXX,
        ST_MUL_YY,
        ST_CMP,
        ST_DONE
    } poc_state_e;

    // One multiplier bit: (2*acc + mbit*a) mod p. With acc, a < p the sum is below 3p,
    // so two conditional subtractions always reduce it.
    function automatic logic [W-1:0] mm_step(input logic [W-1:0] acc,
                                             input logic         mbit,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] p);
        logic [W+1:0] t;
        logic [W+1:0] pw;
        pw = {2'b00, p};
        t  = {1'b0, acc, 1'b0} + (mbit ? {2'b00, a} : {(W+2){1'b0}});
        if (t >= pw) t = t - pw;
        if (t >= pw) t = t - pw;
        return t[W-1:0];
    endfunction

endpackage

// File: rtl/point_on_curve_check_if.sv
// Request/response bundle for the point-on-curve checker.
interface point_on_curve_check_if;
    import point_on_curve_check_pkg::*;

    logic         start;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         busy;
    logic         done;
    logic         on_curve;
    logic         range_err;

    modport master (output start, x, y, input busy, done, on_curve, range_err);
    modport slave  (input start, x, y, output busy, done, on_curve, range_err);
endinterface

// File: rtl/point_on_curve_check_mul.sv
// Bit-serial interleaved modular multiplier, MSB first, fixed 256-cycle latency.
// The first bit is consumed on the start edge so back-to-back multiplies chain without gaps.
module mod_mul_serial
    import point_on_curve_check_pkg::*;
#(
    parameter logic [W-1:0] P_MOD = SECP_P
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] r
);

    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (!busy_q && start) begin
            a_d    = a;
            b_d    = {b[W-2:0], 1'b0};
            acc_d  = mm_step('0, b[W-1], a, P_MOD);
            cnt_d  = CNT_W'(1);
            busy_d = 1'b1;
        end else if (busy_q) begin
            acc_d = mm_step(acc_q, b_q[W-1], a_q, P_MOD);
            b_d   = {b_q[W-2:0], 1'b0};
            if (cnt_q == '1) begin
                busy_d = 1'b0;
                done_d = 1'b1;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign r    = acc_q;

endmodule

// File: rtl/point_on_curve_check.sv
// Checks y^2 == x^3 + b (mod p) for an affine point using one shared serial multiplier.
module point_on_curve_check
    import point_on_curve_check_pkg::*;
#(
    parameter logic [W-1:0] P_MOD  = SECP_P,
    parameter logic [W-1:0] B_COEF = SECP_B
) (
    input logic                      clk,
    input logic                      reset,
    point_on_curve_check_if.slave    bus
);

    poc_state_e   state_q, state_d;
    logic [W-1:0] x_q, x_d;
    logic [W-1:0] y_q, y_d;
    logic [W-1:0] t2_q, t2_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         on_curve_q, on_curve_d;
    logic         range_err_q, range_err_d;

    logic         mul_start_c;
    logic [W-1:0] mul_a_c;
    logic [W-1:0] mul_b_c;
    logic         mul_busy;
    logic         mul_done;
    logic [W-1:0] mul_r;
    logic [W:0]   rhs_sum_c;
    logic [W-1:0] rhs_c;

    mod_mul_serial #(.P_MOD(P_MOD)) u_mul (
        .clk   (clk),
        .reset (reset),
        .start (mul_start_c),
        .a     (mul_a_c),
        .b     (mul_b_c),
        .busy  (mul_busy),
        .done  (mul_done),
        .r     (mul_r)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            t2_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            on_curve_q  <= 1'b0;
            range_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            t2_q        <= t2_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            on_curve_q  <= on_curve_d;
            range_err_q <= range_err_d;
        end
    end

    // Each multiply is launched on the edge that leaves the previous state, so the
    // next operand pair is presented while the finished product is still on mul_r.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        t2_d        = t2_q;
        on_curve_d  = on_curve_q;
        range_err_d = range_err_q;
        mul_start_c = 1'b0;
        mul_a_c     = '0;
        mul_b_c     = '0;

        rhs_sum_c = {1'b0, t2_q} + {1'b0, B_COEF};
        rhs_c     = (rhs_sum_c >= {1'b0, P_MOD}) ? W'(rhs_sum_c - {1'b0, P_MOD})
                                                 : rhs_sum_c[W-1:0];

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    x_d     = bus.x;
                    y_d     = bus.y;
                    state_d = ST_CHK;
                end
            end
            ST_CHK: begin
                if (x_q >= P_MOD || y_q >= P_MOD) begin
                    range_err_d = 1'b1;
                    on_curve_d  = 1'b0;
                    state_d     = ST_DONE;
                end else if (!mul_busy) begin
                    mul_start_c = 1'b1;
                    mul_a_c     = x_q;
                    mul_b_c     = x_q;
                    state_d     = ST_MUL_XX;
                end
            end
            ST_MUL_XX: begin
                if (mul_done) begin
                    mul_start_c = 1'b1;
                    mul_a_c     = mul_r;
                    mul_b_c     = x_q;
                    state_d     = ST_MUL_XXX;
                end
            end
            ST_MUL_XXX: begin
                if (mul_done) begin
                    t2_d        = mul_r;
                    mul_start_c = 1'b1;
                    mul_a_c     = y_q;
                    mul_b_c     = y_q;
                    state_d     = ST_MUL_YY;
                end
            end
            ST_MUL_YY: begin
                if (mul_done) state_d = ST_CMP;
            end
            ST_CMP: begin
                on_curve_d  = (mul_r == rhs_c);
                range_err_d = 1'b0;
                state_d     = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy_d = (state_d != ST_IDLE);
    assign done_d = (state_d == ST_DONE);

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.on_curve  = on_curve_q;
    assign bus.range_err = range_err_q;

endmodule

// File: tb/tb_point_on_curve_check.sv
// Randomised scoreboard bench for point_on_curve_check against a plain modular-arithmetic model.
module tb_point_on_curve_check;
    import point_on_curve_check_pkg::*;

    typedef struct {
        logic  on;
        logic  rng;
        int    cyc;
        string tag;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    logic last_on;
    logic last_rng;

    localparam logic [W-1:0] GX2 = 256'hC6047F9441ED7D6D3045406E95C07CD85C778E4B8CEF3CA7ABAC09B95C709EE5;
    localparam logic [W-1:0] GY2 = 256'h1AE168FEA63DC339A3C58419466CEAEEF7F632653266D0E1236431A950CFE52A;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    point_on_curve_check_if bus();

    point_on_curve_check dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [W-1:0] rand256();
        logic [W-1:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic logic [W-1:0] mulmod(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] t;
        t = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        t = t % {{W{1'b0}}, SECP_P};
        return t[W-1:0];
    endfunction

    function automatic logic [W-1:0] addmod(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] t;
        t = ({1'b0, a} + {1'b0, b}) % {1'b0, SECP_P};
        return t[W-1:0];
    endfunction

    function automatic logic [W-1:0] powmod(input logic [W-1:0] base, input logic [W-1:0] e);
        logic [W-1:0] res;
        res = 256'd1;
        for (int i = W - 1; i >= 0; i--) begin
            res = mulmod(res, res);
            if (e[i]) res = mulmod(res, base);
        end
        return res;
    endfunction

    // Random point on the curve: p = 3 mod 4, so sqrt(v) = v^((p+1)/4) when v is a square.
    function automatic void rand_on_curve(output logic [W-1:0] xo, output logic [W-1:0] yo);
        logic [W-1:0] rhs;
        logic [W-1:0] e;
        logic         found;
        e     = (SECP_P + 256'd1) >> 2;
        found = 1'b0;
        xo    = SECP_GX;
        yo    = SECP_GY;
        for (int k = 0; k < 64 && !found; k++) begin
            logic [W-1:0] xc;
            logic [W-1:0] yc;
            xc  = rand256() % SECP_P;
            rhs = addmod(mulmod(mulmod(xc, xc), xc), SECP_B);
            yc  = powmod(rhs, e);
            if (mulmod(yc, yc) == rhs) begin
                xo    = xc;
                yo    = yc;
                found = 1'b1;
            end
        end
    endfunction

    function automatic logic model_rng(input logic [W-1:0] xi, input logic [W-1:0] yi);
        return (xi >= SECP_P) || (yi >= SECP_P);
    endfunction

    function automatic logic model_on(input logic [W-1:0] xi, input logic [W-1:0] yi);
        if (model_rng(xi, yi)) return 1'b0;
        return mulmod(yi, yi) == addmod(mulmod(mulmod(xi, xi), xi), SECP_B);
    endfunction

    task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, req, cyc);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest outstanding request.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected none (cyc %0d)", cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    cmp({e.tag, "_done_cycle"}, W'(cyc), W'(e.cyc));
                    cmp({e.tag, "_on_curve"}, W'(bus.on_curve), W'(e.on));
                    cmp({e.tag, "_range_err"}, W'(bus.range_err), W'(e.rng));
                end
            end
        end
    end

    // Called at a falling edge. start is held for (skip+1) cycles; the DUT must accept it on
    // the last of those edges. Done is expected in cycle 771 (or 2 on a range error), where
    // cycle N is the one ending at the N-th rising edge after the accepting edge.
    task automatic drive_start(input logic [W-1:0] xi, input logic [W-1:0] yi,
                               input bit push, input int skip, input string tag);
        exp_t e;
        bus.start = 1'b1;
        bus.x     = xi;
        bus.y     = yi;
        repeat (skip) @(negedge clk);
        if (push) begin
            e.rng = model_rng(xi, yi);
            e.on  = model_on(xi, yi);
            e.cyc = cyc + (e.rng ? 2 : 771);
            e.tag = tag;
            exp_q.push_back(e);
            last_on  = e.on;
            last_rng = e.rng;
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.x     = rand256();
        bus.y     = rand256();
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (bus.done !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done expected done within 1000 cycles", tag);
        end
    endtask

    task automatic run_check(input logic [W-1:0] xi, input logic [W-1:0] yi, input string tag);
        @(negedge clk);
        drive_start(xi, yi, 1'b1, 0, tag);
        wait_done(tag);
    endtask

    task automatic check_hold(input string tag);
        repeat (3) @(negedge clk);
        cmp({tag, "_hold_on"}, W'(bus.on_curve), W'(last_on));
        cmp({tag, "_hold_rng"}, W'(bus.range_err), W'(last_rng));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] rx;
        logic [W-1:0] ry;
        bus.start = 1'b0;
        bus.x     = '0;
        bus.y     = '0;
        reset     = 1'b0;
        repeat (3) @(negedge clk);
        cmp("reset_busy", W'(bus.busy), '0);
        cmp("reset_done", W'(bus.done), '0);
        cmp("reset_on", W'(bus.on_curve), '0);
        cmp("reset_rng", W'(bus.range_err), '0);
        reset = 1'b1;

        run_check(SECP_GX, SECP_GY, "gen");
        check_hold("gen");
        run_check(SECP_GX, SECP_GY + 256'd1, "gen_y1");
        run_check(SECP_P, '0, "x_eq_p");
        check_hold("x_eq_p");
        run_check('0, '0, "zero");
        run_check(SECP_P - 256'd1, '0, "x_pm1");

        // A second start while busy must be dropped.
        @(negedge clk);
        drive_start(SECP_GX, SECP_GY, 1'b1, 0, "repulse");
        repeat (98) @(negedge clk);
        cmp("repulse_busy", W'(bus.busy), W'(1));
        bus.start = 1'b1;
        bus.x     = '0;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("repulse");

        // Reset mid-operation aborts without a done pulse.
        @(negedge clk);
        drive_start(SECP_GX, SECP_GY, 1'b0, 0, "abort");
        repeat (299) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        cmp("abort_busy", W'(bus.busy), '0);
        cmp("abort_done", W'(bus.done), '0);
        repeat (800) @(negedge clk);
        run_check(SECP_GX, SECP_GY, "restart");

        run_check(GX2, GY2, "dbl_g");

        for (int i = 0; i < 4; i++) begin
            rand_on_curve(rx, ry);
            run_check(rx, ry, "rand_on");
        end
        for (int i = 0; i < 2; i++) run_check(rand256() % SECP_P, rand256() % SECP_P, "rand_any");
        run_check(SECP_P + {224'b0, $urandom()}, rand256() % SECP_P, "rand_xbig");
        run_check(rand256() % SECP_P, SECP_P + {240'b0, 16'($urandom())}, "rand_ybig");

        // Start raised during the DONE cycle is ignored there and accepted in the next IDLE.
        run_check(GX2, GY2, "b2b_a");
        drive_start(SECP_GX, SECP_GY, 1'b1, 1, "b2b_b");
        wait_done("b2b_b");
        check_hold("b2b_b");

        repeat (2) @(negedge clk);
        cmp("queue_empty", W'(exp_q.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
